seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_if.sv | 22 ++
 rtl/seg_scan_ctrl.sv | 78 +++++++
 tb/tb_seg_scan_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// Display scan bus: load/contents in, digit drive and frame status out.
interface seg_scan_if;
  logic        load;
  logic [15:0] value;
  logic [3:0]  blank_mask;
  logic [3:0]  dp_mask;
  logic [3:0]  an;
  logic [3:0]  nib;
  logic        dp;
  logic        pending;
  logic        frame_tick;

  modport master (
    output load, value, blank_mask, dp_mask,
    input  an, nib, dp, pending, frame_tick
  );

  modport slave (
    input  load, value, blank_mask, dp_mask,
    output an, nib, dp, pending, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-seg scan controller.
// Staged contents swap into the shown copy only at frame boundaries.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000
) (
  input logic       clk,
  input logic       reset,
  seg_scan_if.slave bus
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  blank;
    logic [3:0]  dpm;
  } disp_t;

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic          slot_end;
  logic          frame;
  logic          pend;
  disp_t         stg;
  disp_t         shd;
  logic          off;

  assign slot_end = (presc == LAST);
  assign frame    = slot_end && (idx == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      idx   <= 2'd0;
    end else if (slot_end) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // shadow copies the pre-edge staging, so a coincident load
  // waits a full frame while an earlier pending one is shown
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg  <= '0;
      shd  <= '0;
      pend <= 1'b0;
    end else begin
      if (frame && pend)
        shd <= stg;
      if (bus.load) begin
        stg  <= '{bus.value, bus.blank_mask, bus.dp_mask};
        pend <= 1'b1;
      end else if (frame) begin
        pend <= 1'b0;
      end
    end
  end

  assign off = shd.blank[idx];

  always_comb begin
    bus.nib = shd.value[{idx, 2'b00} +: 4];
    bus.an  = 4'hF;
    bus.dp  = 1'b1;
    if (!off) begin
      bus.an  = ~(4'b0001 << idx);
      bus.dp  = ~shd.dpm[idx];
    end
  end

  assign bus.pending    = pend;
  assign bus.frame_tick = frame;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with REFRESH_DIV=4.
module tb_seg_scan_ctrl;

  localparam int DIV = 4;
  localparam int FRM = 4 * DIV;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  blank;
    logic [3:0]  dpm;
  } disp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seg_scan_if bus ();

  seg_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int nchk = 0;
  int nerr = 0;

  int    m_t;
  disp_t m_stg;
  disp_t m_shd;
  logic  m_pend;
  logic [10:0] sb[$];

  logic [3:0] antab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] model_out();
    int k;
    logic [3:0] an_e;
    logic [3:0] nib_e;
    logic dp_e;
    logic tk;
    k = (m_t / DIV) % 4;
    nib_e = 4'((m_shd.value >> (4 * k)) & 16'hF);
    if (m_shd.blank[k]) begin
      an_e = 4'hF;
      dp_e = 1'b1;
    end else begin
      an_e = antab[k];
      dp_e = !m_shd.dpm[k];
    end
    tk = ((m_t % FRM) == FRM - 1);
    return {an_e, nib_e, dp_e, m_pend, tk};
  endfunction

  function automatic logic [10:0] dut_out();
    return {bus.an, bus.nib, bus.dp, bus.pending, bus.frame_tick};
  endfunction

  task automatic mreset();
    m_t = 0;
    m_stg = '0;
    m_shd = '0;
    m_pend = 1'b0;
  endtask

  task automatic step(input logic ld, input logic [15:0] v,
                      input logic [3:0] b, input logic [3:0] d);
    logic frame;
    bus.load = ld;
    bus.value = v;
    bus.blank_mask = b;
    bus.dp_mask = d;
    frame = ((m_t % FRM) == FRM - 1);
    if (frame && m_pend)
      m_shd = m_stg;
    if (ld) begin
      m_stg = '{v, b, d};
      m_pend = 1'b1;
    end else if (frame) begin
      m_pend = 1'b0;
    end
    m_t++;
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    check($sformatf("out@%0d", m_t), 32'(dut_out()),
          32'(sb.pop_front()));
    bus.load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  task automatic to_boundary();
    for (int i = 0; i < FRM && (m_t % FRM) != FRM - 1; i++) idle(1);
  endtask

  task automatic to_slot(input int s);
    for (int i = 0; i < FRM && ((m_t / DIV) % 4) != s; i++) idle(1);
  endtask

  task automatic rst_step(input logic ld);
    bus.load = ld;
    bus.value = 16'hBEEF;
    sb.push_back(11'b1110_0000_1_0_0);
    @(posedge clk);
    #1;
    check("in_rst", 32'(dut_out()), 32'(sb.pop_front()));
    bus.load = 1'b0;
  endtask

  initial begin
    bus.load = 1'b0;
    bus.value = '0;
    bus.blank_mask = '0;
    bus.dp_mask = '0;
    mreset();
    #2;
    check("rst_an", 32'(bus.an), 32'h0000000E);
    check("rst_nib", 32'(bus.nib), 32'h0);
    check("rst_dp", 32'(bus.dp), 32'h1);
    check("rst_pend", 32'(bus.pending), 32'h0);
    check("rst_tick", 32'(bus.frame_tick), 32'h0);
    rst_step(1'b1);
    rst_step(1'b0);
    reset = 1'b0;

    // idle scan
    idle(2 * FRM);

    // single load mid-frame
    to_boundary();
    idle(6);
    step(1'b1, 16'h1A2F, 4'h0, 4'h0);
    idle(2 * FRM);

    // two loads in one frame, only the last shown
    to_boundary();
    idle(4);
    step(1'b1, 16'h1111, 4'h0, 4'h0);
    idle(5);
    step(1'b1, 16'h2222, 4'h0, 4'h0);
    idle(2 * FRM);

    // load on boundary with nothing pending
    to_boundary();
    step(1'b1, 16'h3333, 4'h0, 4'h0);
    check("coin_pend", 32'(bus.pending), 32'h1);
    check("coin_nib", 32'(bus.nib), 32'h2);
    idle(2 * FRM);

    // load on boundary with a load already pending
    to_boundary();
    idle(3);
    step(1'b1, 16'h4444, 4'h0, 4'h0);
    to_boundary();
    step(1'b1, 16'h5555, 4'h0, 4'h0);
    check("coin2_nib", 32'(bus.nib), 32'h4);
    idle(2 * FRM);

    // blanking and decimal points
    step(1'b1, 16'h8765, 4'b0100, 4'b0101);
    idle(2 * FRM);
    to_slot(2);
    check("blank_an", 32'(bus.an), 32'hF);
    check("blank_dp", 32'(bus.dp), 32'h1);
    to_slot(0);
    check("dp0", 32'(bus.dp), 32'h0);
    check("dp0_nib", 32'(bus.nib), 32'h5);

    // random traffic
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 4) == 0), 16'($urandom),
           4'($urandom), 4'($urandom));

    // reset in the middle of slot 2 with a load pending
    to_boundary();
    idle(2);
    step(1'b1, 16'h9ABC, 4'h0, 4'h3);
    to_slot(2);
    idle(1);
    #2;
    reset = 1'b1;
    mreset();
    #1;
    check("mid_an", 32'(bus.an), 32'h0000000E);
    check("mid_pend", 32'(bus.pending), 32'h0);
    check("mid_nib", 32'(bus.nib), 32'h0);
    rst_step(1'b1);
    rst_step(1'b0);
    reset = 1'b0;
    step(1'b1, 16'hC0DE, 4'h0, 4'h0);
    idle(FRM - 2);
    check("tick_after", 32'(bus.frame_tick), 32'h1);
    idle(2 * FRM);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
